// File: rtl/apb3_dm_spi_master_if.sv
// APB3 bus bundle for apb3_dm_spi_master.
// Signals:
//   PADDR   byte address (only [4:2] decoded by the slave)
//   PSEL, PENABLE, PWRITE  APB3 control
//   PWDATA  write data
//   PRDATA  read data, PREADY ready (always 1), PSLVERR error response
// Modports: master drives the request, slave drives the response.
interface apb3_dm_spi_master_if;
  logic [7:0]  PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb3_dm_spi_master.sv
// APB3 slave feeding a TX FIFO that is serialised MSB-first over SPI mode 0 to a
// deformable-mirror DAC chain. Status and the last received word are readable over APB.
// Ports:
//   HCLK, HRESET  clock and synchronous active-high reset
//   apb           APB3 slave bundle (PADDR/PSEL/PENABLE/PWRITE/PWDATA in, PRDATA/PREADY/PSLVERR out)
//   SCLK, MOSI    SPI clock (idles 0) and serial data out, registered
//   MISO          serial data in
//   CS_N          chip select, active low, registered
//   IRQ           interrupt, registered (only when DM_SPI_IRQ_EN is defined)
// Optional feature: define DM_SPI_IRQ_EN to add the IRQ port and the IRQEN register at 0x10.
module apb3_dm_spi_master #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                HCLK,
  input  logic                HRESET,
  apb3_dm_spi_master_if.slave apb,
  output logic                SCLK,
  output logic                MOSI,
  input  logic                MISO,
  output logic                CS_N
`ifdef DM_SPI_IRQ_EN
  ,
  output logic                IRQ
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned BitW = $clog2(DATA_W);

  localparam logic [2:0] OffCtrl   = 3'd0;
  localparam logic [2:0] OffStatus = 3'd1;
  localparam logic [2:0] OffTx     = 3'd2;
  localparam logic [2:0] OffRx     = 3'd3;
  localparam logic [2:0] OffIrqEn  = 3'd4;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StGap} state_e;

  // ---------------- APB decode ----------------
  logic [2:0] idx;
  logic       access, err;
  logic       sel_ctrl, sel_status, sel_tx, sel_rx, sel_irqen, decoded;
  logic       ctrl_wr, status_wr, push, ovf_set, clr_fire;
  logic       fifo_empty, fifo_full;

  assign idx    = apb.PADDR[4:2];
  assign access = apb.PSEL & apb.PENABLE;

  always_comb begin
    sel_ctrl   = (idx == OffCtrl);
    sel_status = (idx == OffStatus);
    sel_tx     = (idx == OffTx);
    sel_rx     = (idx == OffRx);
`ifdef DM_SPI_IRQ_EN
    sel_irqen  = (idx == OffIrqEn);
`else
    sel_irqen  = 1'b0;
`endif
    decoded    = sel_ctrl | sel_status | sel_tx | sel_rx | sel_irqen;
  end

  always_comb begin
    err = 1'b0;
    if (!decoded) begin
      err = 1'b1;
    end else if (sel_rx && apb.PWRITE) begin
      err = 1'b1;
    end else if (sel_tx && !apb.PWRITE) begin
      err = 1'b1;
    end else if (sel_tx && fifo_full) begin
      err = 1'b1;
    end
  end

  assign apb.PSLVERR = access & err;
  assign apb.PREADY  = 1'b1;

  assign ctrl_wr   = access & apb.PWRITE & ~err & sel_ctrl;
  assign status_wr = access & apb.PWRITE & ~err & sel_status;
  assign push      = access & apb.PWRITE & ~err & sel_tx;
  assign ovf_set   = access & apb.PWRITE & sel_tx & fifo_full;
  assign clr_fire  = ctrl_wr & apb.PWDATA[1];

  // ---------------- Control / status registers ----------------
  logic              en_q, ovf_q;
  logic [7:0]        div_q;
  logic [DATA_W-1:0] rxdata_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      en_q  <= 1'b0;
      div_q <= 8'd0;
      ovf_q <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en_q  <= apb.PWDATA[0];
        div_q <= apb.PWDATA[15:8];
      end
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (status_wr && apb.PWDATA[3]) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   level_q;
  logic              pop_req, push_eff, pop_eff;
  logic [DATA_W-1:0] fifo_head;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == CntW'(FIFO_DEPTH));
  assign fifo_head  = mem_q[rd_ptr_q];
  // A flush in the same cycle discards the incoming word.
  assign push_eff   = push & ~clr_fire;
  assign pop_eff    = pop_req & ~fifo_empty;

  always_ff @(posedge HCLK) begin
    if (push_eff) begin
      mem_q[wr_ptr_q] <= apb.PWDATA[DATA_W-1:0];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET || clr_fire) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_eff)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_eff, pop_eff})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // ---------------- Shift engine ----------------
  state_e            state_q, state_d;
  logic [8:0]        cnt_q;
  logic              ph_q;
  logic [BitW-1:0]   bit_q;
  logic [7:0]        div_l_q;
  logic [DATA_W-1:0] sh_q, rxsh_q, rx_next;
  logic              half_done, gap_done, last_bit, start, sample, busy;
  logic              cs_n_d, sclk_d, mosi_d;

  assign half_done = (cnt_q == {1'b0, div_l_q});
  assign gap_done  = (cnt_q == {div_l_q, 1'b1});
  assign last_bit  = (bit_q == BitW'(DATA_W - 1));
  assign busy      = (state_q != StIdle);
  // Don't start a word on the same edge that disables the engine or flushes the FIFO.
  assign start     = en_q & ~(ctrl_wr & ~apb.PWDATA[0]) & ~fifo_empty & ~clr_fire;
  assign rx_next   = sample ? {rxsh_q[DATA_W-2:0], MISO} : rxsh_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = StShift;
      StShift: if (half_done && ph_q && last_bit) state_d = StGap;
      StGap:   if (gap_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pop_req = 1'b0;
    sample  = 1'b0;
    cs_n_d  = 1'b1;
    sclk_d  = 1'b0;
    mosi_d  = 1'b0;
    unique case (state_q)
      StLoad: begin
        pop_req = 1'b1;
        cs_n_d  = 1'b0;
        mosi_d  = fifo_head[DATA_W-1];
      end
      StShift: begin
        cs_n_d = 1'b0;
        sclk_d = ph_q;
        mosi_d = sh_q[DATA_W-1];
        // First cycle of the high phase lines up with the registered SCLK rising.
        sample = ph_q & (cnt_q == 9'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cnt_q    <= 9'd0;
      ph_q     <= 1'b0;
      bit_q    <= '0;
      div_l_q  <= 8'd0;
      sh_q     <= '0;
      rxsh_q   <= '0;
      rxdata_q <= '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          sh_q    <= fifo_head;
          div_l_q <= div_q;
          cnt_q   <= 9'd0;
          ph_q    <= 1'b0;
          bit_q   <= '0;
        end
        StShift: begin
          rxsh_q <= rx_next;
          if (half_done) begin
            cnt_q <= 9'd0;
            ph_q  <= ~ph_q;
            if (ph_q) begin
              sh_q  <= {sh_q[DATA_W-2:0], 1'b0};
              bit_q <= bit_q + 1'b1;
              if (last_bit) rxdata_q <= rx_next;
            end
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        StGap:   cnt_q <= cnt_q + 9'd1;
        default: ;
      endcase
    end
  end

  // SPI pins are registered so they are glitch-free.
  logic cs_n_q, sclk_q, mosi_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cs_n_q <= 1'b1;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      cs_n_q <= cs_n_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
    end
  end

  assign CS_N = cs_n_q;
  assign SCLK = sclk_q;
  assign MOSI = mosi_q;

`ifdef DM_SPI_IRQ_EN
  logic [1:0] irqen_q;
  logic       irq_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      irqen_q <= 2'b00;
      irq_q   <= 1'b0;
    end else begin
      if (access && apb.PWRITE && sel_irqen) irqen_q <= apb.PWDATA[1:0];
      irq_q <= (irqen_q[0] & fifo_empty & ~busy & en_q) | (irqen_q[1] & ovf_q);
    end
  end

  assign IRQ = irq_q;
`endif

  // ---------------- Read mux ----------------
  logic [31:0] rdata;
  logic [5:0]  level_ext;

  // LEVEL widened so a 32-deep FIFO can report 32; bit 13 is always 0 for depth <= 16.
  assign level_ext = 6'(level_q);

  always_comb begin
    rdata = 32'd0;
    if (sel_ctrl) begin
      rdata = {16'd0, div_q, 7'd0, en_q};
    end else if (sel_status) begin
      rdata = {18'd0, level_ext, 4'd0, ovf_q, fifo_full, fifo_empty, busy};
    end else if (sel_rx) begin
      rdata = 32'(rxdata_q);
    end
`ifdef DM_SPI_IRQ_EN
    else if (sel_irqen) begin
      rdata = {30'd0, irqen_q};
    end
`endif
  end

  assign apb.PRDATA = apb.PSEL ? rdata : 32'd0;

  logic unused_bits;
  assign unused_bits = ^{apb.PADDR[7:5], apb.PADDR[1:0], apb.PWDATA};

endmodule

// File: tb/tb_apb3_dm_spi_master.sv
// Directed self-checking bench for apb3_dm_spi_master (DATA_W=24, FIFO_DEPTH=16).
// MISO is looped back to MOSI. A background monitor records every CS_N low pulse.
module tb_apb3_dm_spi_master;
  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  logic sclk, mosi, cs_n;
`ifdef DM_SPI_IRQ_EN
  logic irq;
`endif
  int checks = 0;
  int errors = 0;

  apb3_dm_spi_master_if bus ();

  apb3_dm_spi_master #(
    .DATA_W    (24),
    .FIFO_DEPTH(16)
  ) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .apb   (bus),
    .SCLK  (sclk),
    .MOSI  (mosi),
    .MISO  (mosi),
    .CS_N  (cs_n)
`ifdef DM_SPI_IRQ_EN
    ,
    .IRQ   (irq)
`endif
  );

  always #5 HCLK = ~HCLK;

  // Pulse monitor: low length, preceding high length and shifted-out word per pulse.
  int          pulses = 0;
  int          lo_run = 0;
  int          hi_run = 0;
  int          lo_len [16];
  int          hi_len [16];
  int          nbits  [16];
  logic [31:0] word   [16];
  logic [31:0] sh = '0;
  int          shn = 0;
  logic        prev_sclk = 1'b0;

  always @(negedge HCLK) begin
    if (HRESET) begin
      pulses = 0; lo_run = 0; hi_run = 0; sh = '0; shn = 0; prev_sclk = 1'b0;
    end else begin
      if (cs_n === 1'b0) begin
        if (lo_run == 0 && pulses < 16) begin
          hi_len[pulses] = hi_run;
          hi_run = 0; sh = '0; shn = 0;
        end
        lo_run++;
        if (sclk === 1'b1 && prev_sclk === 1'b0) begin
          sh = {sh[30:0], mosi};
          shn++;
        end
      end else begin
        if (lo_run != 0 && pulses < 16) begin
          lo_len[pulses] = lo_run;
          word[pulses]   = sh;
          nbits[pulses]  = shn;
          pulses++;
          lo_run = 0;
        end
        hi_run++;
      end
      prev_sclk = sclk;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic e);
    @(negedge HCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = a; bus.PWRITE = 1'b1; bus.PWDATA = d;
    @(negedge HCLK);
    bus.PENABLE = 1'b1;
    #1 e = bus.PSLVERR;
    @(posedge HCLK);
    #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
    @(negedge HCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = a; bus.PWRITE = 1'b0;
    @(negedge HCLK);
    bus.PENABLE = 1'b1;
    #1 begin d = bus.PRDATA; e = bus.PSLVERR; end
    @(posedge HCLK);
    #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int bound);
    int k = 0;
    while (pulses < n && k < bound) begin
      @(posedge HCLK); #1 k++;
    end
    check("pulse_count", 32'(pulses), 32'(n));
  endtask

  task automatic wait_cs_low(input string tag, input int bound);
    int k = 0;
    while (cs_n !== 1'b0 && k < bound) begin
      @(posedge HCLK); #1 k++;
    end
    check(tag, {31'd0, cs_n}, 32'd0);
  endtask

  initial begin
    logic        err;
    logic [31:0] rd;
    int          esum;
    int          p0;
    int          k;

    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = 8'h00; bus.PWDATA = 32'h0;

    // ---- Reset ----
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    check("rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("rst_sclk", {31'd0, sclk}, 32'd0);
    check("rst_mosi", {31'd0, mosi}, 32'd0);
    check("rst_pready", {31'd0, bus.PREADY}, 32'd1);
    check("rst_prdata_idle", bus.PRDATA, 32'd0);
    check("rst_pslverr", {31'd0, bus.PSLVERR}, 32'd0);
`ifdef DM_SPI_IRQ_EN
    check("rst_irq", {31'd0, irq}, 32'd0);
`endif
    apb_read(8'h04, rd, err);
    check("rst_status", rd, 32'h0000_0002);
    apb_read(8'h00, rd, err);
    check("rst_ctrl", rd, 32'h0);
    apb_read(8'h0C, rd, err);
    check("rst_rxdata", rd, 32'h0);

    // ---- Single word, DIV=1, loopback ----
    apb_write(8'h00, 32'h0000_0101, err);
    apb_write(8'h08, 32'h00A5_C30F, err);
    check("tx_push_err", {31'd0, err}, 32'd0);
    check("lat_e0", {31'd0, cs_n}, 32'd1);
    @(posedge HCLK); #1;
    check("lat_e1", {31'd0, cs_n}, 32'd1);
    @(posedge HCLK); #1;
    check("lat_e2", {31'd0, cs_n}, 32'd0);
    // Hold a read setup on RXDATA to observe it the first cycle CS_N is high.
    bus.PSEL = 1'b1; bus.PADDR = 8'h0C; bus.PWRITE = 1'b0; bus.PENABLE = 1'b0;
    k = 0;
    while (cs_n !== 1'b1 && k < 300) begin
      @(negedge HCLK); k++;
    end
    check("rx_first_high", bus.PRDATA, 32'h00A5_C30F);
    bus.PSEL = 1'b0;
    wait_pulses(1, 20);
    check("single_low_len", 32'(lo_len[0]), 32'd97);
    check("single_nbits", 32'(nbits[0]), 32'd24);
    check("single_mosi", word[0], 32'h00A5_C30F);
    repeat (10) @(posedge HCLK);
    apb_read(8'h0C, rd, err);
    check("single_rxdata", rd, 32'h00A5_C30F);
    apb_read(8'h04, rd, err);
    check("single_status_idle", rd, 32'h0000_0002);
    apb_read(8'h00, rd, err);
    check("ctrl_readback", rd, 32'h0000_0101);

    // ---- Fill with EN=0 ----
    apb_write(8'h00, 32'h0, err);
    esum = 0;
    for (int i = 0; i < 16; i++) begin
      apb_write(8'h08, 32'h0010_0000 + 32'(i), err);
      esum += int'(err);
    end
    check("fill_16_no_err", 32'(esum), 32'd0);
    apb_write(8'h08, 32'h00DE_AD00, err);
    check("fill_17_pslverr", {31'd0, err}, 32'd1);
    apb_read(8'h04, rd, err);
    check("fill_status", rd, 32'h0000_100C);
    apb_read(8'h08, rd, err);
    check("rd_tx_pslverr", {31'd0, err}, 32'd1);
    check("rd_tx_data", rd, 32'd0);
    apb_write(8'h0C, 32'h1, err);
    check("wr_rx_pslverr", {31'd0, err}, 32'd1);
    apb_read(8'h14, rd, err);
    check("undecoded_pslverr", {31'd0, err}, 32'd1);
    check("undecoded_data", rd, 32'd0);
`ifndef DM_SPI_IRQ_EN
    apb_read(8'h10, rd, err);
    check("irqen_absent_pslverr", {31'd0, err}, 32'd1);
`endif
    apb_write(8'h04, 32'h8, err);
    check("ovf_clr_err", {31'd0, err}, 32'd0);
    apb_read(8'h04, rd, err);
    check("ovf_cleared", rd, 32'h0000_1004);
    apb_write(8'h00, 32'h2, err);
    apb_read(8'h04, rd, err);
    check("clr_flush", rd, 32'h0000_0002);
    apb_read(8'h00, rd, err);
    check("clr_self_clear", rd, 32'h0);

    // ---- Back-to-back, DIV=0 ----
    apb_write(8'h08, 32'h0012_3456, err);
    apb_write(8'h08, 32'h00FE_DCBA, err);
    apb_write(8'h08, 32'h0000_0001, err);
    apb_write(8'h00, 32'h1, err);
    wait_pulses(4, 600);
    check("b2b_len1", 32'(lo_len[1]), 32'd49);
    check("b2b_len2", 32'(lo_len[2]), 32'd49);
    check("b2b_len3", 32'(lo_len[3]), 32'd49);
    check("b2b_word1", word[1], 32'h0012_3456);
    check("b2b_word2", word[2], 32'h00FE_DCBA);
    check("b2b_word3", word[3], 32'h0000_0001);
    check("b2b_gap2_min", {31'd0, hi_len[2] >= 3}, 32'd1);
    check("b2b_gap3_min", {31'd0, hi_len[3] >= 3}, 32'd1);
    repeat (10) @(posedge HCLK);
    apb_read(8'h0C, rd, err);
    check("b2b_rxdata", rd, 32'h0000_0001);

    // ---- DIV latched at LOAD, then mid-word disable+clear ----
    apb_write(8'h00, 32'h0000_0100, err);
    apb_write(8'h08, 32'h005A_5A5A, err);
    apb_write(8'h08, 32'h000F_0F0F, err);
    apb_write(8'h08, 32'h0033_3333, err);
    p0 = pulses;
    apb_write(8'h00, 32'h0000_0101, err);
    wait_cs_low("mid_start1", 20);
    repeat (40) @(posedge HCLK);
    apb_write(8'h00, 32'h0000_0001, err);
    wait_pulses(p0 + 1, 200);
    check("div_latched_len", 32'(lo_len[p0]), 32'd97);
    check("div_latched_word", word[p0], 32'h005A_5A5A);
    wait_cs_low("mid_start2", 20);
    apb_read(8'h04, rd, err);
    check("mid_status_busy", rd, 32'h0000_0101);
    repeat (10) @(posedge HCLK);
    apb_write(8'h00, 32'h0000_0002, err);
    wait_pulses(p0 + 2, 200);
    check("mid_word_len", 32'(lo_len[p0 + 1]), 32'd49);
    check("mid_word_data", word[p0 + 1], 32'h000F_0F0F);
    repeat (10) @(posedge HCLK);
    apb_read(8'h04, rd, err);
    check("mid_status_after", rd, 32'h0000_0002);
    repeat (150) @(posedge HCLK);
    check("mid_no_more_pulses", 32'(pulses), 32'(p0 + 2));

`ifdef DM_SPI_IRQ_EN
    // ---- IRQ on completion ----
    apb_write(8'h08, 32'h0000_00AA, err);
    apb_write(8'h10, 32'h1, err);
    apb_read(8'h10, rd, err);
    check("irqen_readback", rd, 32'h1);
    check("irq_off_en0", {31'd0, irq}, 32'd0);
    p0 = pulses;
    apb_write(8'h00, 32'h1, err);
    wait_cs_low("irq_start", 20);
    check("irq_low_busy", {31'd0, irq}, 32'd0);
    wait_pulses(p0 + 1, 200);
    k = 0;
    while (irq !== 1'b1 && k < 10) begin
      @(posedge HCLK); #1 k++;
    end
    check("irq_rise", {31'd0, irq}, 32'd1);
    apb_write(8'h00, 32'h0, err);
    @(posedge HCLK); #1;
    check("irq_drop", {31'd0, irq}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
